// File: rtl/imm_decode_stage_pkg.sv
// Shared decode definitions: extender operation encodings, opcode constants
// and the decoded-bundle layout carried through the decode stage.
package imm_decode_stage_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_HIGH = 2'b10
    } extOp_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm16;
        extOp_e      extOp;
        logic        illegal;
    } decoded_t;

    // Raw field split only; extOp/illegal come from imm_ctrl_decode.
    function automatic decoded_t splitFields(input logic [31:0] instr);
        decoded_t d;
        d.opcode  = instr[31:26];
        d.rs      = instr[25:21];
        d.rt      = instr[20:16];
        d.rd      = instr[15:11];
        d.funct   = instr[5:0];
        d.imm16   = instr[15:0];
        d.extOp   = EXT_ZERO;
        d.illegal = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/imm_ctrl_decode.sv
// Combinational opcode-to-extender control map; unsupported opcodes are
// flagged illegal and default to zero extension.
module imm_ctrl_decode
    import imm_decode_stage_pkg::*;
(
    input  logic [5:0] opcode,
    output extOp_e     extOp,
    output logic       illegal
);

    always_comb begin
        extOp   = EXT_ZERO;
        illegal = 1'b0;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_BEQ, OP_BNE, OP_LW, OP_SW:       extOp = EXT_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:           extOp = EXT_ZERO;
            OP_LUI:                             extOp = EXT_HIGH;
            OP_RTYPE, OP_J:                     extOp = EXT_ZERO;
            default:                            illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage feeding the immediate extender: decodes at accept,
// buffers through a main/skid pair so in_ready stays a flop output.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [5:0]       out_funct,
    output logic [15:0]      out_imm16,
    output logic [1:0]       out_ext_op,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decode_cnt
);

    logic             mainValid, skidValid, inReadyQ;
    decoded_t         mainData, skidData, inData;
    logic [PC_W-1:0]  mainPc, skidPc;
    logic [CNT_W-1:0] decodeCnt;
    extOp_e           inExtOp;
    logic             inIllegal;

    logic accept, handoff;
    logic mainValidNext, skidValidNext;
    logic mainFromSkid, mainFromIn, skidFromIn;

    imm_ctrl_decode uCtrl (
        .opcode  (in_instr[31:26]),
        .extOp   (inExtOp),
        .illegal (inIllegal)
    );

    always_comb begin
        inData         = splitFields(in_instr);
        inData.extOp   = inExtOp;
        inData.illegal = inIllegal;
    end

    assign accept  = in_valid && inReadyQ;
    assign handoff = mainValid && out_ready;

    // in_ready mirrors !skidValid, so an accept never coincides with a full skid.
    always_comb begin
        mainValidNext = mainValid;
        skidValidNext = skidValid;
        mainFromSkid  = 1'b0;
        mainFromIn    = 1'b0;
        skidFromIn    = 1'b0;
        if (flush) begin
            mainValidNext = 1'b0;
            skidValidNext = 1'b0;
        end else if (!mainValid || handoff) begin
            if (skidValid) begin
                mainFromSkid  = 1'b1;
                mainValidNext = 1'b1;
                skidValidNext = 1'b0;
            end else begin
                mainFromIn    = accept;
                mainValidNext = accept;
            end
        end else if (accept) begin
            skidFromIn    = 1'b1;
            skidValidNext = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            inReadyQ  <= 1'b1;
            mainData  <= '0;
            skidData  <= '0;
            mainPc    <= '0;
            skidPc    <= '0;
            decodeCnt <= '0;
        end else begin
            mainValid <= mainValidNext;
            skidValid <= skidValidNext;
            inReadyQ  <= !skidValidNext;
            if (mainFromSkid) begin
                mainData <= skidData;
                mainPc   <= skidPc;
            end else if (mainFromIn) begin
                mainData <= inData;
                mainPc   <= in_pc;
            end
            if (skidFromIn) begin
                skidData <= inData;
                skidPc   <= in_pc;
            end
            if (handoff && !flush)
                decodeCnt <= decodeCnt + CNT_W'(1);
        end
    end

    assign in_ready    = inReadyQ;
    assign out_valid   = mainValid;
    assign out_pc      = mainPc;
    assign out_opcode  = mainData.opcode;
    assign out_rs      = mainData.rs;
    assign out_rt      = mainData.rt;
    assign out_rd      = mainData.rd;
    assign out_funct   = mainData.funct;
    assign out_imm16   = mainData.imm16;
    assign out_ext_op  = mainData.extOp;
    assign out_illegal = mainData.illegal;
    assign decode_cnt  = decodeCnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: one task per scenario, inputs driven
// and outputs sampled on the falling clock edge.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, decode_cnt;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [15:0] out_imm16;
    logic [1:0]  out_ext_op;
    logic        out_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.PC_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_funct(out_funct), .out_imm16(out_imm16), .out_ext_op(out_ext_op),
        .out_illegal(out_illegal), .decode_cnt(decode_cnt)
    );

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b required=1", in_ready); end
        checks++; if (decode_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt actual=%0d required=0", decode_cnt); end
        checks++; if (out_imm16 !== 16'h0 || out_pc !== 32'h0 || out_ext_op !== 2'b00) begin
            failures++; $display("FAIL reset_data actual=%h/%h/%b required=0/0/00", out_imm16, out_pc, out_ext_op); end
        rst_n = 1'b1;
    endtask

    task automatic test_ori();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h34088000; in_pc = 32'h00400000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ori_valid actual=%b required=1", out_valid); end
        checks++; if (out_imm16 !== 16'h8000) begin failures++; $display("FAIL ori_imm actual=%h required=8000", out_imm16); end
        checks++; if (out_ext_op !== 2'b00) begin failures++; $display("FAIL ori_ext actual=%b required=00", out_ext_op); end
        checks++; if (out_rt !== 5'd8 || out_rs !== 5'd0 || out_opcode !== 6'h0D) begin
            failures++; $display("FAIL ori_fields actual=rt%0d rs%0d op%h required=rt8 rs0 op0d", out_rt, out_rs, out_opcode); end
        checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL ori_illegal actual=%b required=0", out_illegal); end
        checks++; if (out_pc !== 32'h00400000) begin failures++; $display("FAIL ori_pc actual=%h required=00400000", out_pc); end
        @(negedge clk);
        checks++; if (decode_cnt !== 32'd1) begin failures++; $display("FAIL ori_cnt actual=%0d required=1", decode_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ori_drain actual=%b required=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [3] = '{32'h2008FFFF, 32'h3C081234, 32'h8D090004};
        logic [1:0]  exts   [3] = '{2'b01, 2'b10, 2'b01};
        logic [15:0] imms   [3] = '{16'hFFFF, 16'h1234, 16'h0004};
        out_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_ext_op !== exts[i-1] || out_imm16 !== imms[i-1]) begin
                    failures++; $display("FAIL b2b_%0d actual=v%b ext%b imm%h required=v1 ext%b imm%h",
                                         i-1, out_valid, out_ext_op, out_imm16, exts[i-1], imms[i-1]); end
            end
            if (i < 3) begin
                in_valid = 1'b1; in_instr = instrs[i]; in_pc = 32'h1000 + 32'(i*4);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (decode_cnt !== 32'd4 || out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_cnt actual=%0d v%b required=4 v0", decode_cnt, out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h20090001; in_pc = 32'h2000;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_imm16 !== 16'h0001 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_first actual=v%b imm%h r%b required=v1 imm0001 r1", out_valid, out_imm16, in_ready); end
        in_instr = 32'h3C0A00AB; in_pc = 32'h2004;
        @(negedge clk);
        in_instr = 32'h340B0CCC; in_pc = 32'h2008;
        for (int c = 0; c < 2; c++) begin
            checks++; if (in_ready !== 1'b0 || out_imm16 !== 16'h0001 || out_pc !== 32'h2000 || out_ext_op !== 2'b01) begin
                failures++; $display("FAIL bp_hold%0d actual=r%b imm%h pc%h required=r0 imm0001 pc2000", c, in_ready, out_imm16, out_pc); end
            @(negedge clk);
        end
        checks++; if (out_imm16 !== 16'h0001 || in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_hold2 actual=imm%h r%b required=imm0001 r0", out_imm16, in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_imm16 !== 16'h00AB || out_ext_op !== 2'b10 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_second actual=v%b imm%h ext%b r%b required=v1 imm00ab ext10 r1", out_valid, out_imm16, out_ext_op, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_imm16 !== 16'h0CCC || out_pc !== 32'h2008) begin
            failures++; $display("FAIL bp_third actual=v%b imm%h pc%h required=v1 imm0ccc pc2008", out_valid, out_imm16, out_pc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || decode_cnt !== 32'd7) begin
            failures++; $display("FAIL bp_cnt actual=v%b cnt%0d required=v0 cnt7", out_valid, decode_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h21000010; in_pc = 32'h3000;
        @(negedge clk);
        in_instr = 32'h21000020; in_pc = 32'h3004;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_full actual=%b required=0", in_ready); end
        flush = 1'b1; out_ready = 1'b1; in_instr = 32'h21000030; in_pc = 32'h3008;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || decode_cnt !== 32'd7) begin
            failures++; $display("FAIL flush_full_clear actual=v%b r%b cnt%0d required=v0 r1 cnt7", out_valid, in_ready, decode_cnt); end
        in_instr = 32'h21000040; in_pc = 32'h300C;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || decode_cnt !== 32'd7) begin
            failures++; $display("FAIL flush_accept actual=v%b cnt%0d required=v0 cnt7", out_valid, decode_cnt); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h4000;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_ext_op !== 2'b00 || out_opcode !== 6'h3F) begin
            failures++; $display("FAIL illegal actual=v%b ill%b ext%b op%h required=v1 ill1 ext00 op3f", out_valid, out_illegal, out_ext_op, out_opcode); end
        @(negedge clk);
        checks++; if (decode_cnt !== 32'd8) begin failures++; $display("FAIL illegal_cnt actual=%0d required=8", decode_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h2008FFFF; in_pc = 32'h5000;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre actual=%b required=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || decode_cnt !== 32'd0 || in_ready !== 1'b1 || out_imm16 !== 16'h0) begin
            failures++; $display("FAIL ar_now actual=v%b cnt%0d r%b imm%h required=v0 cnt0 r1 imm0000", out_valid, decode_cnt, in_ready, out_imm16); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_residual actual=%b required=0", out_valid); end
        in_valid = 1'b1; in_instr = 32'h3C08BEEF; in_pc = 32'h6000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_imm16 !== 16'hBEEF || out_ext_op !== 2'b10) begin
            failures++; $display("FAIL ar_after actual=v%b imm%h ext%b required=v1 immbeef ext10", out_valid, out_imm16, out_ext_op); end
        @(negedge clk);
        checks++; if (decode_cnt !== 32'd1) begin failures++; $display("FAIL ar_cnt actual=%0d required=1", decode_cnt); end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
